// File: rtl/fft64_reorder.sv
// ---------------------------------------------------------------------------
// fft64_reorder
//   Output reorder buffer for the tail of a 64-point SDF FFT. Bins arrive in
//   bit-reversed order, one complex sample per accepted cycle, and leave in
//   natural order (bin 0..63) over a valid/ready interface. Two 64-entry
//   banks are used ping-pong style, so frame n+1 can be written while frame n
//   is read out.
//
//   Build option: define FFT_REORDER_OVF_EN to add a sticky overflow flag
//   (ovf) with a synchronous clear (ovf_clr). The flag records any sample
//   offered while in_ready was low.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input sample present
//   in_sof     sample is bit-reversed index 0 of a frame (resyncs the writer)
//   in_re/im   input sample, WIDTH-bit two's complement
//   in_ready   a bank has room; sample accepted iff in_valid && in_ready
//   out_valid  out_* hold a valid bin
//   out_ready  downstream accepts; transfer iff out_valid && out_ready
//   out_re/im  output sample, bit-exact copy of the input
//   out_index  natural-order bin number of the current output
//   out_last   high with bin 63
//   ovf        (FFT_REORDER_OVF_EN only) sticky dropped-sample flag
//   ovf_clr    (FFT_REORDER_OVF_EN only) clears ovf, wins over a set
// ---------------------------------------------------------------------------
module fft64_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last
`ifdef FFT_REORDER_OVF_EN
    ,
    output logic             ovf,
    input  logic             ovf_clr
`endif
);

    localparam int N  = 1 << LOG2N;
    localparam int DW = 2 * WIDTH;

    // Both banks live in one array; the bank select is the address MSB.
    logic [DW-1:0] mem [0:2*N-1];

    // Write side state
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_cnt_q,  wr_cnt_d;
    logic [1:0]       full_q,    full_d;

    // Read side state
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q,  rd_cnt_d;
    logic             done_q,    done_d;     // bin 63 of the read bank is in the output register

    // Output registers
    logic             out_valid_q, out_valid_d;
    logic [LOG2N-1:0] out_index_q, out_index_d;
    logic             out_last_q,  out_last_d;
    logic [DW-1:0]    out_data_q;

    // Combinational helpers
    logic [LOG2N-1:0] wr_cnt_rev;
    logic [LOG2N-1:0] wr_addr;
    logic             in_ready_w;
    logic             wr_accept;
    logic             wr_wrap;
    logic             out_xfer;
    logic             last_xfer;
    logic             rd_adv;
    logic             rd_bank_eff;
    logic [LOG2N-1:0] rd_cnt_eff;
    logic             rd_load;
    logic [LOG2N:0]   rd_raddr;

    // Bit reversal of the write counter is pure wiring.
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
        assign wr_cnt_rev[gi] = wr_cnt_q[LOG2N-1-gi];
    end

    always_comb begin
        // Input side is ready when the write bank is free. The read bank's
        // storage is released as soon as its final entry sits in the output
        // register, so a new frame may start overwriting it while bin 63 waits
        // for out_ready. Only the completing write (count 63) must wait for
        // the bank to actually be marked empty, otherwise the full flag would
        // be set and cleared on top of each other. All terms are registered
        // state; out_ready never feeds in_ready.
        in_ready_w = ~full_q[wr_bank_q]
                   | (done_q & (wr_bank_q == rd_bank_q) & ~(&wr_cnt_q));

        wr_accept = in_valid & in_ready_w;
        wr_addr   = in_sof ? '0 : wr_cnt_rev;
        wr_wrap   = wr_accept & ~in_sof & (&wr_cnt_q);

        wr_cnt_d  = wr_cnt_q;
        if (wr_accept) begin
            // A start-of-frame always lands at address 0 and restarts the count,
            // abandoning whatever partial frame was in the bank.
            wr_cnt_d = in_sof ? LOG2N'(1) : wr_cnt_q + LOG2N'(1);
        end
        wr_bank_d = wr_bank_q ^ wr_wrap;

        out_xfer  = out_valid_q & out_ready;
        last_xfer = out_xfer & out_last_q;
        rd_adv    = ~out_valid_q | out_ready;

        // When bin 63 leaves this cycle, the next load already comes from the
        // other bank so back-to-back frames have no bubble.
        rd_bank_eff = rd_bank_q ^ last_xfer;
        rd_cnt_eff  = last_xfer ? '0 : rd_cnt_q;
        rd_load     = rd_adv & full_q[rd_bank_eff] & (last_xfer | ~done_q);
        rd_raddr    = {rd_bank_eff, rd_cnt_eff};

        full_d = full_q;
        if (last_xfer) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_wrap) begin
            full_d[wr_bank_q] = 1'b1;
        end

        rd_bank_d   = rd_bank_eff;
        rd_cnt_d    = rd_cnt_eff;
        done_d      = done_q & ~last_xfer;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        if (rd_load) begin
            rd_cnt_d    = rd_cnt_eff + LOG2N'(1);
            done_d      = &rd_cnt_eff;
            out_valid_d = 1'b1;
            out_index_d = rd_cnt_eff;
            out_last_d  = &rd_cnt_eff;
        end else if (rd_adv) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Sample storage: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank_q, wr_addr}] <= {in_re, in_im};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            // Registered memory read doubles as the output data register.
            if (rd_load) begin
                out_data_q <= mem[rd_raddr];
            end
        end
    end

`ifdef FFT_REORDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end else if (in_valid & ~in_ready_w) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_q;
    assign out_re    = out_data_q[DW-1:WIDTH];
    assign out_im    = out_data_q[WIDTH-1:0];
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule
